fractal_sync_mp: RTL and testbench

//  Core-side master port feeding a leaf fractal_sync 1D node input port.

---
 rtl/fractal_sync_pkg.sv | 31 +++
 rtl/fractal_sync_wdog.sv | 32 +++
 rtl/fractal_sync_mp.sv | 150 +++++++++++++++
 tb/tb_fractal_sync_mp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal_sync core-side master port: sync direction,
// master-port FSM states and error codes.
package fractal_sync_pkg;

    typedef enum logic [1:0] {
        SD_NONE = 2'b00,
        SD_UP   = 2'b01,
        SD_DOWN = 2'b10,
        SD_BOTH = 2'b11
    } sd_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } mp_state_e;

    typedef enum logic [1:0] {
        MP_ERR_NONE    = 2'b00,
        MP_ERR_NODE    = 2'b01,
        MP_ERR_TIMEOUT = 2'b10
    } mp_err_e;

    // Counter width able to hold the value 'limit' itself.
    function automatic int unsigned wdog_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/fractal_sync_wdog.sv
// Saturating barrier watchdog: cleared on clr_i, counts while en_i, and
// flags the cycle that completes LIMIT enabled cycles.
module fractal_sync_wdog
    import fractal_sync_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = wdog_width(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt < CW'(LIMIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt counts completed enabled cycles, so LIMIT-1 marks the LIMIT-th one.
    assign expired_o = en_i & (r_cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/fractal_sync_mp.sv
// Core-side master port for a leaf fractal_sync node: one barrier in flight,
// single-cycle fsync request, wake matching, sticky error reporting.
// Optional watchdog enabled by defining FRACTAL_SYNC_MP_TIMEOUT_EN.
module fractal_sync_mp
    import fractal_sync_pkg::*;
#(
    parameter int unsigned AGGREGATE_WIDTH = 1,
    parameter int unsigned ID_WIDTH        = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sync_req_i,
    input  logic [AGGREGATE_WIDTH-1:0] sync_aggr_i,
    input  logic [ID_WIDTH-1:0]        sync_id_i,
    input  logic [1:0]                 sync_sd_i,
    output logic                       sync_gnt_o,
    output logic                       sync_done_o,
    output logic                       sync_busy_o,
    output logic                       sync_error_o,
    output logic [1:0]                 sync_err_code_o,
    input  logic                       sync_err_clr_i,
    output logic                       spurious_o,
    output logic                       fsync_req_valid_o,
    output logic [AGGREGATE_WIDTH-1:0] fsync_req_aggr_o,
    output logic [ID_WIDTH-1:0]        fsync_req_id_o,
    output logic [1:0]                 fsync_req_sd_o,
    input  logic                       fsync_rsp_wake_i,
    input  logic [AGGREGATE_WIDTH-1:0] fsync_rsp_aggr_i,
    input  logic [ID_WIDTH-1:0]        fsync_rsp_id_i,
    input  logic                       fsync_rsp_error_i
);

    mp_state_e                  r_state;
    mp_err_e                    r_err_code;
    logic [AGGREGATE_WIDTH-1:0] r_aggr;
    logic [ID_WIDTH-1:0]        r_id;
    logic [1:0]                 r_sd;
    logic                       r_done;
    logic                       r_busy;
    logic                       r_valid;
    logic                       r_error;
    logic                       r_spurious;

    logic w_gnt;
    logic w_match;
    logic w_expired;

    assign w_gnt   = (r_state == IDLE) & sync_req_i;
    assign w_match = fsync_rsp_wake_i & (fsync_rsp_aggr_i == r_aggr) & (fsync_rsp_id_i == r_id);

`ifdef FRACTAL_SYNC_MP_TIMEOUT_EN
    fractal_sync_wdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_gnt),
        .en_i     (r_state == WAIT),
        .expired_o(w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_err_code <= MP_ERR_NONE;
            r_aggr     <= '0;
            r_id       <= '0;
            r_sd       <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_spurious <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_spurious <= fsync_rsp_wake_i;
                    if (w_gnt) begin
                        r_aggr  <= sync_aggr_i;
                        r_id    <= sync_id_i;
                        r_sd    <= sync_sd_i;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    r_spurious <= fsync_rsp_wake_i;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (fsync_rsp_error_i) begin
                        r_error    <= 1'b1;
                        r_err_code <= MP_ERR_NODE;
                        r_busy     <= 1'b0;
                        r_state    <= ERR;
                    end else if (w_match) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_spurious <= fsync_rsp_wake_i;
                        if (w_expired) begin
                            r_error    <= 1'b1;
                            r_err_code <= MP_ERR_TIMEOUT;
                            r_busy     <= 1'b0;
                            r_state    <= ERR;
                        end
                    end
                end
                DONE: begin
                    r_spurious <= fsync_rsp_wake_i;
                    r_state    <= IDLE;
                end
                ERR: begin
                    if (sync_err_clr_i) begin
                        r_error    <= 1'b0;
                        r_err_code <= MP_ERR_NONE;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sync_gnt_o        = w_gnt;
    assign sync_done_o       = r_done;
    assign sync_busy_o       = r_busy;
    assign sync_error_o      = r_error;
    assign sync_err_code_o   = r_err_code;
    assign spurious_o        = r_spurious;
    assign fsync_req_valid_o = r_valid;
    assign fsync_req_aggr_o  = r_aggr;
    assign fsync_req_id_o    = r_id;
    assign fsync_req_sd_o    = r_sd;

endmodule

// File: tb/tb_fractal_sync_mp.sv
// Self-checking bench for fractal_sync_mp: directed scenarios plus randomized
// barriers checked against a transaction-level expectation model.
module tb_fractal_sync_mp;

    localparam int AW = 2;
    localparam int IW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, clr, wake, werr;
    logic [AW-1:0] aggr, waggr;
    logic [IW-1:0] id, wid;
    logic [1:0]    sd;
    logic          gnt, done, busy, error, spur, valid;
    logic [1:0]    code, rsd;
    logic [AW-1:0] raggr;
    logic [IW-1:0] rid;

    int n_checks = 0;
    int n_fail   = 0;

    fractal_sync_mp #(
        .AGGREGATE_WIDTH(AW),
        .ID_WIDTH       (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .sync_req_i       (req),
        .sync_aggr_i      (aggr),
        .sync_id_i        (id),
        .sync_sd_i        (sd),
        .sync_gnt_o       (gnt),
        .sync_done_o      (done),
        .sync_busy_o      (busy),
        .sync_error_o     (error),
        .sync_err_code_o  (code),
        .sync_err_clr_i   (clr),
        .spurious_o       (spur),
        .fsync_req_valid_o(valid),
        .fsync_req_aggr_o (raggr),
        .fsync_req_id_o   (rid),
        .fsync_req_sd_o   (rsd),
        .fsync_rsp_wake_i (wake),
        .fsync_rsp_aggr_i (waggr),
        .fsync_rsp_id_i   (wid),
        .fsync_rsp_error_i(werr)
    );

    always #5 clk = ~clk;

    // Each cycle: edge, +1 drive inputs, +2 sample outputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        req = 1'b0; clr = 1'b0; wake = 1'b0; werr = 1'b0;
        aggr = '0; id = '0; sd = '0; waggr = '0; wid = '0;
    endtask

    task automatic drive_wake(input logic [AW-1:0] a, input logic [IW-1:0] i);
        wake = 1'b1; waggr = a; wid = i;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1;
        #12;
        n_checks++; if ({gnt, done, busy, error, spur, valid} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000", {gnt, done, busy, error, spur, valid}); end
        n_checks++; if ({code, rsd, raggr, rid} !== 8'b0) begin n_fail++; $display("FAIL reset_fields: got %h want 00", {code, rsd, raggr, rid}); end
        rst = 1'b0;
        cyc(); #1;
        n_checks++; if ({busy, valid, error} !== 3'b0) begin n_fail++; $display("FAIL reset_release: got %b want 000", {busy, valid, error}); end
    endtask

    // Scenario 1: gnt@0, valid@1, wake@5, done@6, busy 1..5.
    task automatic test_basic();
        cyc(); req = 1'b1; aggr = 2'd1; id = 2'd3; sd = 2'd2; #1;
        n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL basic_gnt: got %b want 1", gnt); end
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({valid, busy} !== 2'b11) begin n_fail++; $display("FAIL basic_send: valid/busy %b want 11", {valid, busy}); end
        n_checks++; if ({raggr, rid, rsd} !== {2'd1, 2'd3, 2'd2}) begin n_fail++; $display("FAIL basic_fields: got %h want %h", {raggr, rid, rsd}, {2'd1, 2'd3, 2'd2}); end
        for (int c = 2; c <= 5; c++) begin
            cyc();
            if (c == 5) drive_wake(2'd1, 2'd3);
            #1;
            n_checks++; if ({busy, valid, done} !== 3'b100) begin n_fail++; $display("FAIL basic_wait_c%0d: busy/valid/done %b want 100", c, {busy, valid, done}); end
        end
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({done, busy, spur} !== 3'b100) begin n_fail++; $display("FAIL basic_done: done/busy/spur %b want 100", {done, busy, spur}); end
        cyc(); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    // Scenario 2: mismatched id in WAIT gives a spurious pulse only.
    task automatic test_mismatch();
        cyc(); req = 1'b1; aggr = 2'd1; id = 2'd3; #1;
        cyc(); quiet_inputs(); #1;
        cyc(); drive_wake(2'd1, 2'd2); #1;
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({spur, done, busy} !== 3'b101) begin n_fail++; $display("FAIL mismatch_spur: spur/done/busy %b want 101", {spur, done, busy}); end
        cyc(); drive_wake(2'd0, 2'd3); #1;
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({spur, done} !== 2'b10) begin n_fail++; $display("FAIL mismatch_aggr: spur/done %b want 10", {spur, done}); end
        cyc(); drive_wake(2'd1, 2'd3); #1;
        n_checks++; if (spur !== 1'b0) begin n_fail++; $display("FAIL mismatch_spur_clear: got %b want 0", spur); end
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({done, spur} !== 2'b10) begin n_fail++; $display("FAIL mismatch_done: done/spur %b want 10", {done, spur}); end
    endtask

    // Scenario 3: error beats wake; ERR ignores wakes; clr returns to IDLE.
    task automatic test_node_error();
        cyc(); werr = 1'b1; #1;
        cyc(); quiet_inputs(); #1;
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_idle_ignored: got %b want 0", error); end
        cyc(); req = 1'b1; aggr = 2'd2; id = 2'd1; #1;
        cyc(); quiet_inputs(); #1;
        cyc(); drive_wake(2'd2, 2'd1); werr = 1'b1; #1;
        cyc(); quiet_inputs(); drive_wake(2'd0, 2'd0); req = 1'b1; #1;
        n_checks++; if ({error, code, done, busy} !== 5'b1_01_00) begin n_fail++; $display("FAIL err_node: error/code/done/busy %b want 101 00", {error, code, done, busy}); end
        n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL err_no_gnt: got %b want 0", gnt); end
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({spur, error} !== 2'b01) begin n_fail++; $display("FAIL err_wake_ignored: spur/error %b want 01", {spur, error}); end
        cyc(); clr = 1'b1; #1;
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", error); end
        cyc(); clr = 1'b0; #1;
        n_checks++; if ({error, code} !== 3'b0) begin n_fail++; $display("FAIL err_clear: error/code %b want 000", {error, code}); end
    endtask

    // Scenario 4: watchdog expiry, and a match on the last WAIT cycle winning.
    task automatic test_timeout();
`ifdef FRACTAL_SYNC_MP_TIMEOUT_EN
        for (int v = 0; v < 2; v++) begin
            cyc(); req = 1'b1; aggr = 2'd3; id = 2'd0; #1;
            cyc(); quiet_inputs(); #1;
            for (int w = 1; w <= TO; w++) begin
                cyc();
                if (v == 1 && w == TO) drive_wake(2'd3, 2'd0);
                #1;
                n_checks++; if ({busy, error} !== 2'b10) begin n_fail++; $display("FAIL to_wait_v%0d_w%0d: busy/error %b want 10", v, w, {busy, error}); end
            end
            cyc(); quiet_inputs(); #1;
            if (v == 0) begin
                n_checks++; if ({error, code, done} !== 4'b1_10_0) begin n_fail++; $display("FAIL to_expire: error/code/done %b want 1100", {error, code, done}); end
                cyc(); clr = 1'b1; #1;
                cyc(); clr = 1'b0; #1;
            end else begin
                n_checks++; if ({error, code, done} !== 4'b0_00_1) begin n_fail++; $display("FAIL to_match_wins: error/code/done %b want 0001", {error, code, done}); end
            end
        end
`else
        cyc(); req = 1'b1; aggr = 2'd3; id = 2'd0; #1;
        cyc(); quiet_inputs(); #1;
        for (int w = 1; w <= 4 * TO; w++) begin
            cyc(); #1;
        end
        n_checks++; if ({busy, error, code} !== 4'b1_0_00) begin n_fail++; $display("FAIL nowdog_persist: busy/error/code %b want 1000", {busy, error, code}); end
        cyc(); drive_wake(2'd3, 2'd0); #1;
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL nowdog_done: done/error %b want 10", {done, error}); end
`endif
    endtask

    // Scenario 5: async reset in WAIT clears everything at once.
    task automatic test_reset_mid_wait();
        cyc(); req = 1'b1; aggr = 2'd1; id = 2'd3; sd = 2'd3; #1;
        cyc(); quiet_inputs(); #1;
        cyc(); #1;
        rst = 1'b1; #1;
        n_checks++; if ({gnt, done, busy, error, spur, valid} !== 6'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000000", {gnt, done, busy, error, spur, valid}); end
        n_checks++; if ({code, rsd, raggr, rid} !== 8'b0) begin n_fail++; $display("FAIL rstmid_fields: got %h want 00", {code, rsd, raggr, rid}); end
        #1; rst = 1'b0;
        cyc(); drive_wake(2'd1, 2'd3); #1;
        cyc(); quiet_inputs(); #1;
        n_checks++; if ({spur, done, busy, error} !== 4'b1000) begin n_fail++; $display("FAIL rstmid_wake: spur/done/busy/error %b want 1000", {spur, done, busy, error}); end
    endtask

    // Scenario 6: request held across two barriers.
    task automatic test_back_to_back();
        cyc(); req = 1'b1; aggr = 2'd2; id = 2'd2; sd = 2'd1; #1;
        n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1", gnt); end
        cyc(); #1;
        n_checks++; if ({valid, gnt} !== 2'b10) begin n_fail++; $display("FAIL b2b_send: valid/gnt %b want 10", {valid, gnt}); end
        cyc(); drive_wake(2'd2, 2'd2); #1;
        n_checks++; if ({valid, gnt} !== 2'b00) begin n_fail++; $display("FAIL b2b_wait: valid/gnt %b want 00", {valid, gnt}); end
        cyc(); wake = 1'b0; #1;
        n_checks++; if ({done, gnt, valid} !== 3'b100) begin n_fail++; $display("FAIL b2b_done: done/gnt/valid %b want 100", {done, gnt, valid}); end
        cyc(); aggr = 2'd1; id = 2'd0; sd = 2'd3; #1;
        n_checks++; if ({gnt, valid, done} !== 3'b100) begin n_fail++; $display("FAIL b2b_gnt2: gnt/valid/done %b want 100", {gnt, valid, done}); end
        cyc(); req = 1'b0; #1;
        n_checks++; if ({valid, raggr, rid, rsd} !== {1'b1, 2'd1, 2'd0, 2'd3}) begin n_fail++; $display("FAIL b2b_send2: got %b want %b", {valid, raggr, rid, rsd}, {1'b1, 2'd1, 2'd0, 2'd3}); end
        cyc(); drive_wake(2'd1, 2'd0); #1;
        cyc(); quiet_inputs(); #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b want 1", done); end
    endtask

    // Random barriers: model predicts done timing, error code and spurious count.
    task automatic test_random();
        logic [AW-1:0] a, m;
        logic [IW-1:0] i, n;
        logic [1:0]    s;
        int            d, errj, exp_sp, obs_sp;
        bit            err_mode, stop;
        for (int b = 0; b < 25; b++) begin
            a = AW'($urandom); i = IW'($urandom); s = 2'($urandom);
            d = $urandom_range(0, 6);
            err_mode = ($urandom_range(0, 3) == 0);
            errj = $urandom_range(0, d);
            exp_sp = 0; obs_sp = 0; stop = 1'b0;
            cyc(); req = 1'b1; aggr = a; id = i; sd = s; #1;
            n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_gnt: got %b want 1", b, gnt); end
            cyc(); quiet_inputs(); #1;
            n_checks++; if ({valid, raggr, rid, rsd} !== {1'b1, a, i, s}) begin n_fail++; $display("FAIL rnd%0d_req: got %b want %b", b, {valid, raggr, rid, rsd}, {1'b1, a, i, s}); end
            for (int j = 0; j <= d; j++) begin
                if (!stop) begin
                    cyc(); quiet_inputs();
                    if (err_mode && j == errj) begin
                        werr = 1'b1; wake = 1'($urandom); waggr = a; wid = i; stop = 1'b1;
                    end else if (j == d) begin
                        drive_wake(a, i);
                    end else if ($urandom_range(0, 1) == 1) begin
                        do begin m = AW'($urandom); n = IW'($urandom); end while (m == 0 && n == 0);
                        drive_wake(a ^ m, i ^ n);
                        exp_sp++;
                    end
                    #1;
                    if (spur) obs_sp++;
                end
            end
            cyc(); quiet_inputs(); #1;
            if (spur) obs_sp++;
            if (err_mode) begin
                n_checks++; if ({error, code, done} !== 4'b1_01_0) begin n_fail++; $display("FAIL rnd%0d_err: error/code/done %b want 1010", b, {error, code, done}); end
                cyc(); clr = 1'b1; #1;
                cyc(); clr = 1'b0; #1;
            end else begin
                n_checks++; if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL rnd%0d_done: done/error/busy %b want 100", b, {done, error, busy}); end
                cyc(); #1;
            end
            n_checks++; if (obs_sp !== exp_sp) begin n_fail++; $display("FAIL rnd%0d_spurious: got %0d pulses want %0d", b, obs_sp, exp_sp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_node_error();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
